mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/arb_priority.sv | 31 +++
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Round-robin arbitration is enabled by defining ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } arb_state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam int DEFAULT_TIMEOUT = 16;

    // Wide enough for the largest legal TIMEOUT (255).
    localparam int CNT_W = 8;

endpackage

// File: rtl/arb_priority.sv
// Picks which port is served when the arbiter leaves IDLE.
// With ARB_ROUND_ROBIN_EN defined, a tie goes to the port not served last.
module arb_priority
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic last_served,
`endif
    output logic any_req,
    output logic winner
);

    assign any_req = if_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        if (if_req && d_req) begin
            winner = ~last_served;
        end else if (d_req) begin
            winner = PORT_D;
        end else begin
            winner = PORT_IF;
        end
    end
`else
    assign winner = d_req ? PORT_D : PORT_IF;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one MMU port between an instruction-fetch port and a data port.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking instead of data-first priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_wen,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic [31:0] mmu_addy,
    output logic [31:0] mmu_datain,
    output logic        mmu_wen,
    output logic        mmu_ren,
    output logic [3:0]  mmu_byte_select,
    input  logic        mmu_nostall,
    input  logic [31:0] mmu_dataout,
    output logic        err,
    output arb_state_t  state_dbg
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;
    logic             wen_q;

    logic             any_req;
    logic             winner;
    logic             busy;
    logic             start;
    logic             timeout_hit;
`ifdef ARB_ROUND_ROBIN_EN
    logic             last_served;
`endif

    arb_priority u_prio (
        .if_req     (if_req),
        .d_req      (d_req),
`ifdef ARB_ROUND_ROBIN_EN
        .last_served(last_served),
`endif
        .any_req    (any_req),
        .winner     (winner)
    );

    assign busy        = (state == BUSY_IF) || (state == BUSY_D);
    assign start       = (state == IDLE) && any_req;
    // Completion has priority: a stall-free edge never counts as a timeout.
    assign timeout_hit = busy && !mmu_nostall && (cnt == CNT_LAST);
    assign state_dbg   = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = (winner == PORT_D) ? BUSY_D : BUSY_IF;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (mmu_nostall || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // MMU signals come only from the transaction registers, never from the ports.
    always_comb begin
        if_gnt          = 1'b0;
        d_gnt           = 1'b0;
        mmu_addy        = 32'h0;
        mmu_datain      = 32'h0;
        mmu_wen         = 1'b0;
        mmu_ren         = 1'b0;
        mmu_byte_select = 4'h0;
        unique case (state)
            BUSY_IF: begin
                if_gnt          = 1'b1;
                mmu_addy        = addr_q;
                mmu_ren         = 1'b1;
                mmu_byte_select = 4'hF;
            end
            BUSY_D: begin
                d_gnt           = 1'b1;
                mmu_addy        = addr_q;
                mmu_datain      = wdata_q;
                mmu_wen         = wen_q;
                mmu_ren         = ~wen_q;
                mmu_byte_select = be_q;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= '0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            be_q     <= 4'h0;
            wen_q    <= 1'b0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if_rdata <= 32'h0;
            d_rdata  <= 32'h0;
            err      <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if (start) begin
                cnt <= '0;
                if (winner == PORT_D) begin
                    addr_q  <= d_addr;
                    wdata_q <= d_wdata;
                    be_q    <= d_be;
                    wen_q   <= d_wen;
                end else begin
                    addr_q  <= if_addr;
                    wdata_q <= 32'h0;
                    be_q    <= 4'hF;
                    wen_q   <= 1'b0;
                end
            end else if (busy && mmu_nostall) begin
                if (state == BUSY_IF) begin
                    if_valid <= 1'b1;
                    if_rdata <= mmu_dataout;
                end else begin
                    d_valid <= 1'b1;
                    if (!wen_q) begin
                        d_rdata <= mmu_dataout;
                    end
                end
            end else if (timeout_hit) begin
                err <= 1'b1;
                if (state == BUSY_IF) begin
                    if_valid <= 1'b1;
                    if_rdata <= 32'h0;
                end else begin
                    d_valid <= 1'b1;
                    d_rdata <= 32'h0;
                end
            end else if (busy) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_served <= PORT_IF;
        end else if (start) begin
            last_served <= winner;
        end
    end
`endif

endmodule
